apb_cmd_requester: RTL and testbench

- APB requester stage sitting directly upstream of the APB UART peripheral (or any APB completer).
- Converts a valid/ready command stream from a CPU-side or test-side source into APB SETUP/ACCESS transfers.
- Waits on PREADY and returns read data and status on a valid/ready response stream.
- One outstanding transfer at a time; no pipelining across transfers.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_req_timer.sv | 37 +++
 rtl/apb_cmd_requester.sv | 137 +++++++++++++
 tb/tb_apb_cmd_requester.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared constants and state encoding for the APB command requester.
package apb_pkg;

  localparam int unsigned DATA_WIDTH         = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_req_state_e;

endpackage

// File: rtl/apb_req_timer.sv
// Saturating ACCESS-phase wait counter; expire fires on the increment that
// would reach LIMIT, so the requester leaves ACCESS after exactly LIMIT waits.
module apb_req_timer #(
  parameter int unsigned LIMIT = 256
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg != CW'(LIMIT))) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign expire = inc && (count_reg >= CW'(LIMIT - 1));

endmodule

// File: rtl/apb_cmd_requester.sv
// Valid/ready command stream to APB SETUP/ACCESS requester, one transfer in flight.
// Optional ACCESS timeout abort is enabled by defining APB_REQ_TIMEOUT_EN.
module apb_cmd_requester
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  apb_req_state_e state_reg;
  apb_req_state_e state_next;

  logic                  pwrite_reg;
  logic [ADDR_WIDTH-1:0] paddr_reg;
  logic [DATA_WIDTH-1:0] pwdata_reg;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg;

  logic cmd_accept;
  logic access_done;
  logic timeout_hit;

  assign cmd_accept  = (state_reg == IDLE) && cmd_valid;
  assign access_done = (state_reg == ACCESS) && (PREADY || timeout_hit);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_valid)   state_next = SETUP;
      SETUP:                    state_next = ACCESS;
      ACCESS:  if (access_done) state_next = RESP;
      RESP:    if (rsp_ready)   state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Moore outputs straight from the state register keep the APB strobes glitch-free.
  always_comb begin
    cmd_ready = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    rsp_valid = 1'b0;
    case (state_reg)
      IDLE:   cmd_ready = 1'b1;
      SETUP:  PSEL      = 1'b1;
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
      end
      RESP:   rsp_valid = 1'b1;
      default: cmd_ready = 1'b0;
    endcase
  end

  // Request fields load only on accept, so they hold through the transfer and while idle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      rsp_rdata_reg <= '0;
    end else begin
      if (cmd_accept) begin
        pwrite_reg <= cmd_write;
        paddr_reg  <= cmd_addr;
        pwdata_reg <= cmd_wdata;
      end
      if (access_done) begin
        rsp_rdata_reg <= (PREADY && !pwrite_reg) ? PRDATA : '0;
      end
    end
  end

  assign PWRITE    = pwrite_reg;
  assign PADDR     = paddr_reg;
  assign PWDATA    = pwdata_reg;
  assign rsp_rdata = rsp_rdata_reg;

`ifdef APB_REQ_TIMEOUT_EN
  logic timer_clr;
  logic timer_inc;
  logic rsp_err_reg;

  assign timer_clr = cmd_accept;
  assign timer_inc = (state_reg == ACCESS) && !PREADY;

  apb_req_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clr     (timer_clr),
    .inc     (timer_inc),
    .expire  (timeout_hit)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_err_reg <= 1'b0;
    end else if (access_done) begin
      rsp_err_reg <= !PREADY;
    end
  end

  assign rsp_err = rsp_err_reg;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_apb_cmd_requester.sv
// Directed bench for apb_cmd_requester: vector table plus backpressure,
// back-to-back, mid-transfer reset and (with APB_REQ_TIMEOUT_EN) timeout sequences.
module tb_apb_cmd_requester;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PREADY = 1'b0;
  logic [31:0] PRDATA = '0;

  int n_cmp = 0;
  int n_err = 0;

  apb_cmd_requester #(
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic [31:0] exp_rdata;
    int          exp_acc;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete transfer; the completer raises PREADY after v.waits ACCESS cycles.
  task automatic run_vec(input vec_t v, input int idx);
    int acc;
    logic [31:0] got_rdata;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    PREADY    = 1'b0;
    check("idle_cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    cmd_addr  = v.addr ^ 32'hFFFF_FFF0;
    cmd_wdata = ~v.wdata;
    check("setup_psel", PSEL, 1);
    check("setup_penable", PENABLE, 0);
    check("setup_paddr", PADDR, v.addr);
    check("setup_pwrite", PWRITE, v.wr);
    check("setup_pwdata", PWDATA, v.wdata);
    check("setup_cmd_ready", cmd_ready, 0);
    step();
    acc = 0;
    while (PSEL && PENABLE && acc < 64) begin
      acc++;
      check("access_paddr", PADDR, v.addr);
      PREADY = (acc > v.waits);
      PRDATA = v.prdata;
      step();
    end
    // PREADY lingers high and PRDATA changes while the response waits.
    PREADY = 1'b1;
    PRDATA = ~v.prdata;
    check("access_cycles", acc, v.exp_acc);
    check("resp_valid", rsp_valid, 1);
    check("resp_psel", PSEL, 0);
    check("resp_penable", PENABLE, 0);
    check("resp_cmd_ready", cmd_ready, 0);
    check("resp_rdata", rsp_rdata, v.exp_rdata);
    check("resp_err", rsp_err, 0);
    got_rdata = rsp_rdata;
    step();
    check("resp_hold_valid", rsp_valid, 1);
    check("resp_hold_rdata", rsp_rdata, v.exp_rdata);
    PREADY    = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("done_rsp_valid", rsp_valid, 0);
    check("done_cmd_ready", cmd_ready, 1);
    check("done_paddr_held", PADDR, v.addr);
    $display("xfer %0d: wr=%0b addr=0x%08h access=%0d rdata=0x%08h err=%0b",
             idx, v.wr, v.addr, acc, got_rdata, rsp_err);
  endtask

  initial begin
    logic [31:0] b2b_addr[8];
    int idx;
    int nrsp;
    int nsetup;
    int cyc;
    int acc;
    logic accepted;
    logic [31:0] exp_rd;

    vecs[0] = '{1'b1, 32'h0000_0004, 32'h0000_0041, 1, 32'hDEAD_BEEF, 32'h0000_0000, 2};
    vecs[1] = '{1'b0, 32'h0000_0008, 32'h1111_2222, 3, 32'h0000_00A5, 32'h0000_00A5, 4};
    vecs[2] = '{1'b0, 32'h0000_000C, 32'h0000_0000, 0, 32'h1234_5678, 32'h1234_5678, 1};
    vecs[3] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 0, 32'h0000_0055, 32'h0000_0000, 1};
    vecs[4] = '{1'b0, 32'h0000_0000, 32'h0BAD_F00D, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6};
    vecs[5] = '{1'b0, 32'h0000_0010, 32'h0000_0003, 1, 32'h0000_0000, 32'h0000_0000, 2};

    b2b_addr = '{32'h0000_0100, 32'h0000_01F0, 32'h0000_0008, 32'h0000_ABC0,
                 32'h0000_0044, 32'h0000_7FFC, 32'h0000_0000, 32'h0000_0020};

    // Reset state
    repeat (3) step();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    PRESETn = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], i);
    end

    // Backpressure: response stalled 10 cycles while a second command waits.
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0020;
    cmd_valid = 1'b1;
    step();
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0024;
    cmd_wdata = 32'h0000_0099;
    check("bp_setup_paddr", PADDR, 32'h20);
    check("bp_setup_cmd_ready", cmd_ready, 0);
    step();
    check("bp_access_penable", PENABLE, 1);
    check("bp_access_cmd_ready", cmd_ready, 0);
    PREADY = 1'b1;
    PRDATA = 32'h0000_0077;
    step();
    for (int i = 0; i < 10; i++) begin
      PRDATA = 32'hCAFE_0000 + i;
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, 32'h77);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_psel", PSEL, 0);
      if (i == 1) PREADY = 1'b0;
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("bp_handshake_idle", cmd_ready, 1);
    check("bp_handshake_rsp_valid", rsp_valid, 0);
    step();
    cmd_valid = 1'b0;
    check("bp_second_psel", PSEL, 1);
    check("bp_second_paddr", PADDR, 32'h24);
    check("bp_second_pwrite", PWRITE, 1);
    check("bp_second_pwdata", PWDATA, 32'h99);
    step();
    PREADY = 1'b1;
    step();
    PREADY = 1'b0;
    check("bp_second_rsp_valid", rsp_valid, 1);
    check("bp_second_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    $display("xfer bp: stalled read 0x20 then write 0x24 accepted after handshake");

    // Back-to-back: 8 commands, zero-wait completer, rsp_ready held high.
    idx = 0; nrsp = 0; nsetup = 0; cyc = 0;
    PREADY = 1'b1;
    rsp_ready = 1'b1;
    while (nrsp < 8 && cyc < 200) begin
      if (idx < 8) begin
        cmd_valid = 1'b1;
        cmd_write = ((idx % 2) == 0);
        cmd_addr  = b2b_addr[idx];
        cmd_wdata = 32'h5000_0000 + idx;
      end else begin
        cmd_valid = 1'b0;
      end
      PRDATA = ~PADDR;
      if (PSEL && !PENABLE && nsetup < 8) begin
        check("b2b_paddr", PADDR, b2b_addr[nsetup]);
        nsetup++;
      end
      if (rsp_valid) begin
        exp_rd = ((nrsp % 2) == 1) ? ~b2b_addr[nrsp] : 32'h0;
        check("b2b_rdata", rsp_rdata, exp_rd);
        $display("xfer b2b %0d: addr=0x%08h rdata=0x%08h", nrsp, b2b_addr[nrsp], rsp_rdata);
        nrsp++;
      end
      accepted = cmd_valid && cmd_ready;
      step();
      cyc++;
      if (accepted) idx++;
    end
    cmd_valid = 1'b0;
    PREADY    = 1'b0;
    rsp_ready = 1'b0;
    check("b2b_total_cycles", cyc, 32);
    check("b2b_setups", nsetup, 8);

    // Reset asserted mid-ACCESS.
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0030;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    check("rstmid_in_access", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    check("rstmid_psel", PSEL, 0);
    check("rstmid_penable", PENABLE, 0);
    check("rstmid_cmd_ready", cmd_ready, 1);
    check("rstmid_paddr", PADDR, 0);
    check("rstmid_rsp_valid", rsp_valid, 0);
    PREADY = 1'b1;
    step();
    step();
    PRESETn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("rstmid_no_rsp", rsp_valid, 0);
      check("rstmid_idle", PSEL, 0);
      step();
    end
    PREADY = 1'b0;
    $display("xfer rst: read 0x30 dropped by reset during ACCESS");

`ifdef APB_REQ_TIMEOUT_EN
    // Timeout: PREADY stuck low, abort after 16 ACCESS cycles.
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0040;
    cmd_valid = 1'b1;
    PRDATA    = 32'h1234_ABCD;
    step();
    cmd_valid = 1'b0;
    step();
    acc = 0;
    while (PSEL && PENABLE && acc < 64) begin
      acc++;
      step();
    end
    check("to_access_cycles", acc, 16);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    $display("xfer to: read 0x40 aborted after %0d ACCESS cycles", acc);
    run_vec(vecs[1], 99);
`else
    acc = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
